// File: rtl/vx_reg_scoreboard.sv
// Register-hazard scoreboard: stages one decoded instruction and releases it only
// when none of its registers has an outstanding write for its warp.
module vx_reg_scoreboard #(
    parameter int NUM_WARPS     = 4,
    parameter int WIS_W         = 2,
    parameter int NUM_REGS      = 64,
    parameter int NR_BITS       = 6,
    parameter int PAYLOAD_W     = 128,
    parameter int STALL_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIS_W-1:0]     in_wis,
    input  logic                 in_wb,
    input  logic [NR_BITS-1:0]   in_rd,
    input  logic [NR_BITS-1:0]   in_rs1,
    input  logic [NR_BITS-1:0]   in_rs2,
    input  logic [NR_BITS-1:0]   in_rs3,
    input  logic [PAYLOAD_W-1:0] in_payload,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIS_W-1:0]     out_wis,
    output logic                 out_wb,
    output logic [NR_BITS-1:0]   out_rd,
    output logic [NR_BITS-1:0]   out_rs1,
    output logic [NR_BITS-1:0]   out_rs2,
    output logic [NR_BITS-1:0]   out_rs3,
    output logic [PAYLOAD_W-1:0] out_payload,

    input  logic                 wb_valid,
    input  logic [WIS_W-1:0]     wb_wis,
    input  logic [NR_BITS-1:0]   wb_rd,
    input  logic                 wb_eop,

    output logic [31:0]          perf_stalls,
    output logic                 deadlock
);

    localparam int CNT_W = $clog2(STALL_TIMEOUT) + 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NUM_REGS-1:0]  pending [NUM_WARPS];

    logic                 stg_valid;
    logic [WIS_W-1:0]     stg_wis;
    logic                 stg_wb;
    logic [NR_BITS-1:0]   stg_rd;
    logic [NR_BITS-1:0]   stg_rs1;
    logic [NR_BITS-1:0]   stg_rs2;
    logic [NR_BITS-1:0]   stg_rs3;
    logic [PAYLOAD_W-1:0] stg_payload;

    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     stall_nxt;

    logic                 rel;
    logic [NUM_REGS-1:0]  rel_row;
    logic [NUM_REGS-1:0]  busy_row;
    logic                 hazard;
    logic                 in_fire;
    logic                 out_fire;

    // Hazard check on the staged instruction; a same-cycle final writeback beat frees its register.
    assign rel      = wb_valid & wb_eop;
    assign rel_row  = (rel && wb_wis == stg_wis) ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wb_rd) : '0;
    assign busy_row = pending[stg_wis] & ~rel_row & {{(NUM_REGS-1){1'b1}}, 1'b0};
    assign hazard   = stg_valid & (busy_row[stg_rs1] | busy_row[stg_rs2] | busy_row[stg_rs3]
                                   | (stg_wb & busy_row[stg_rd]));

    assign out_valid = stg_valid & ~hazard;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = ~stg_valid | out_fire;
    assign in_fire   = in_valid & in_ready;
    assign stall_nxt = sat_inc_cnt(stall_cnt);

    assign out_wis     = stg_wis;
    assign out_wb      = stg_wb;
    assign out_rd      = stg_rd;
    assign out_rs1     = stg_rs1;
    assign out_rs2     = stg_rs2;
    assign out_rs3     = stg_rs3;
    assign out_payload = stg_payload;

    // Staging register control and stall accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid   <= 1'b0;
            stall_cnt   <= '0;
            perf_stalls <= '0;
            deadlock    <= 1'b0;
        end else begin
            if (in_fire) begin
                stg_valid <= 1'b1;
            end else if (out_fire) begin
                stg_valid <= 1'b0;
            end
            if (hazard) begin
                stall_cnt   <= stall_nxt;
                perf_stalls <= sat_inc32(perf_stalls);
                if (stall_nxt == CNT_W'(STALL_TIMEOUT)) begin
                    deadlock <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            stg_wis     <= in_wis;
            stg_wb      <= in_wb;
            stg_rd      <= in_rd;
            stg_rs1     <= in_rs1;
            stg_rs2     <= in_rs2;
            stg_rs3     <= in_rs3;
            stg_payload <= in_payload;
        end
    end

    // Pending-write table: the set on issue is written last so it wins over a same-cycle release.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pending[w] <= '0;
            end
        end else begin
            if (rel) begin
                pending[wb_wis][wb_rd] <= 1'b0;
            end
            if (out_fire && stg_wb && stg_rd != '0) begin
                pending[stg_wis][stg_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_reg_scoreboard.sv
// Bench for vx_reg_scoreboard: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_vx_reg_scoreboard;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_wb;
    logic [1:0]   in_wis;
    logic [5:0]   in_rd, in_rs1, in_rs2, in_rs3;
    logic [127:0] in_payload;
    logic         out_valid, out_ready, out_wb;
    logic [1:0]   out_wis;
    logic [5:0]   out_rd, out_rs1, out_rs2, out_rs3;
    logic [127:0] out_payload;
    logic         wb_valid, wb_eop;
    logic [1:0]   wb_wis;
    logic [5:0]   wb_rd;
    logic [31:0]  perf_stalls;
    logic         deadlock;

    int total = 0;
    int bad   = 0;

    vx_reg_scoreboard #(
        .NUM_WARPS(4), .WIS_W(2), .NUM_REGS(64), .NR_BITS(6),
        .PAYLOAD_W(128), .STALL_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_wb(in_wb),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_wis(out_wis), .out_wb(out_wb),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_payload(out_payload),
        .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .perf_stalls(perf_stalls), .deadlock(deadlock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the staged instruction, a table of outstanding writes, run length of stalls.
    bit          armed = 0;
    bit          mpend [4][64];
    bit          msv;
    int          mwis, mrd, mr1, mr2, mr3;
    bit          mwb;
    logic [127:0] mpay;
    logic [31:0] mperf;
    int          mrun;
    bit          mdl;

    function automatic bit mbusy(input int w, input int r);
        bit freed;
        freed = wb_valid && wb_eop && (int'(wb_wis) == w) && (int'(wb_rd) == r);
        return (r != 0) && mpend[w][r] && !freed;
    endfunction

    always @(negedge clk) begin
        bit hz, eov, eir;
        hz  = msv && (mbusy(mwis, mr1) || mbusy(mwis, mr2) || mbusy(mwis, mr3) ||
                      (mwb && mbusy(mwis, mrd)));
        eov = msv && !hz;
        eir = !msv || (eov && out_ready);
        if (armed) begin
            chk("m_out_valid", 128'(out_valid), 128'(eov));
            chk("m_in_ready", 128'(in_ready), 128'(eir));
            chk("m_perf", 128'(perf_stalls), 128'(mperf));
            chk("m_deadlock", 128'(deadlock), 128'(mdl));
            if (msv) begin
                chk("m_wis", 128'(out_wis), 128'(mwis));
                chk("m_wb", 128'(out_wb), 128'(mwb));
                chk("m_rd", 128'(out_rd), 128'(mrd));
                chk("m_rs1", 128'(out_rs1), 128'(mr1));
                chk("m_rs2", 128'(out_rs2), 128'(mr2));
                chk("m_rs3", 128'(out_rs3), 128'(mr3));
                chk("m_payload", out_payload, mpay);
            end
        end
        if (reset) begin
            armed = 1;
            foreach (mpend[w, r]) mpend[w][r] = 0;
            msv = 0; mperf = 0; mrun = 0; mdl = 0;
        end else begin
            if (hz) begin
                if (mperf != 32'hFFFF_FFFF) mperf = mperf + 1;
                mrun++;
                if (mrun >= TMO) mdl = 1;
            end else begin
                mrun = 0;
            end
            if (wb_valid && wb_eop) mpend[wb_wis][wb_rd] = 0;
            if (eov && out_ready && mwb && mrd != 0) mpend[mwis][mrd] = 1;
            if (eir && in_valid) begin
                msv = 1; mwis = int'(in_wis); mwb = in_wb; mrd = int'(in_rd);
                mr1 = int'(in_rs1); mr2 = int'(in_rs2); mr3 = int'(in_rs3); mpay = in_payload;
            end else if (eov && out_ready) begin
                msv = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int w, input bit wb, input int rd,
                          input int r1, input int r2, input int r3);
        in_valid   = v;
        in_wis     = 2'(w);
        in_wb      = wb;
        in_rd      = 6'(rd);
        in_rs1     = 6'(r1);
        in_rs2     = 6'(r2);
        in_rs3     = 6'(r3);
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    logic [127:0] p1, p2;

    initial begin
        reset = 1; out_ready = 1;
        wb_valid = 0; wb_eop = 0; wb_wis = 0; wb_rd = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        reset = 0;

        // Fill
        set_in(1, 0, 1, 5, 1, 2, 0);
        @(negedge clk);
        chk("fill_in_ready", 128'(in_ready), 128'(1));
        chk("fill_out_valid_empty", 128'(out_valid), 128'(0));
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("fill_out_valid", 128'(out_valid), 128'(1));
        cyc();

        // RAW stall, then release in the writeback cycle
        set_in(1, 0, 0, 6, 5, 0, 0);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("raw_blocked", 128'(out_valid), 128'(0));
        chk("raw_perf0", 128'(perf_stalls), 128'(0));
        cyc();
        @(negedge clk);
        chk("raw_perf1", 128'(perf_stalls), 128'(1));
        cyc();
        wb_valid = 1; wb_eop = 1; wb_wis = 0; wb_rd = 5;
        @(negedge clk);
        chk("raw_released", 128'(out_valid), 128'(1));
        chk("raw_perf2", 128'(perf_stalls), 128'(2));
        cyc(); wb_valid = 0; wb_eop = 0;

        // Multi-beat writeback
        set_in(1, 1, 1, 7, 0, 0, 0);
        cyc();
        set_in(1, 1, 0, 0, 0, 7, 0);
        cyc(); in_valid = 0;
        wb_valid = 1; wb_eop = 0; wb_wis = 1; wb_rd = 7;
        @(negedge clk);
        chk("mb_beat0", 128'(out_valid), 128'(0));
        cyc();
        @(negedge clk);
        chk("mb_beat1", 128'(out_valid), 128'(0));
        cyc(); wb_eop = 1;
        @(negedge clk);
        chk("mb_eop", 128'(out_valid), 128'(1));
        cyc(); wb_valid = 0; wb_eop = 0;

        // Other warps and register 0
        set_in(1, 0, 1, 5, 0, 0, 0);
        cyc();
        set_in(1, 1, 0, 3, 5, 5, 5);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("other_warp", 128'(out_valid), 128'(1));
        cyc();
        set_in(1, 2, 1, 0, 0, 0, 0);
        cyc();
        set_in(1, 2, 1, 0, 0, 0, 0);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("x0_free", 128'(out_valid), 128'(1));
        cyc();

        // Backpressure
        out_ready = 0;
        set_in(1, 3, 0, 10, 1, 2, 3); p1 = in_payload;
        cyc(); in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_payload", out_payload, p1);
            cyc();
        end
        set_in(1, 3, 0, 11, 0, 0, 0); p2 = in_payload;
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("bp_next_valid", 128'(out_valid), 128'(1));
        chk("bp_next_payload", out_payload, p2);
        cyc();

        // Deadlock: pending[0][5] is never released
        set_in(1, 0, 0, 0, 0, 0, 5);
        cyc(); in_valid = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == TMO - 1) chk("dl_before", 128'(deadlock), 128'(0));
            if (k == TMO)     chk("dl_set", 128'(deadlock), 128'(1));
            if (k == 20) begin
                chk("dl_held", 128'(deadlock), 128'(1));
                chk("dl_blocked", 128'(out_valid), 128'(0));
            end
            cyc();
        end
        reset = 1;
        cyc(); reset = 0;
        @(negedge clk);
        chk("rst_deadlock", 128'(deadlock), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_perf", 128'(perf_stalls), 128'(0));
        set_in(1, 0, 0, 0, 5, 5, 5);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("rst_pending_clear", 128'(out_valid), 128'(1));
        cyc();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = $urandom_range(0, 1);
            wb_eop    = ($urandom_range(0, 3) != 0);
            wb_wis    = 2'($urandom_range(0, 3));
            wb_rd     = 6'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 399) == 0);
            cyc();
        end
        reset = 0; in_valid = 0; wb_valid = 0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
